snes_cpu_bus_master: RTL and testbench

Cartridge-side bus initiator: it turns simple host read/write requests into SNES CPU bus cycles that drive the LoROM/HiROM/DSP/OBC1 mappers. It generates the address, read and write strobes, the ROMSEL_N/RAMSEL_N decode and the SYSCLKF_CE/SYSCLKR_CE phase enables, each with per-region access timing. It samples the mapper's returned data and hands it back to the requester. Between requests it runs continuous idle cycles, so mapper-side logic clocked by the phase enables (open-bus latch, OBC1, SRTC) keeps running.

---
 rtl/snes_cpu_bus_master.sv | 145 ++++++++++++++
 tb/tb_snes_cpu_bus_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_cpu_bus_master.sv
// Cartridge-side SNES CPU bus initiator: turns host requests into timed bus cycles
// with region-dependent length, and keeps running idle cycles between requests.
module snes_cpu_bus_master #(
  parameter int FAST_LEN  = 6,
  parameter int SLOW_LEN  = 8,
  parameter int XSLOW_LEN = 12
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        MEMSEL,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [23:0] REQ_ADDR,
  input  logic        REQ_WE,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic [23:0] CA,
  output logic [7:0]  BUS_DO,
  input  logic [7:0]  BUS_DI,
  output logic        CPURD_N,
  output logic        CPUWR_N,
  output logic        ROMSEL_N,
  output logic        RAMSEL_N,
  output logic        SYSCLKF_CE,
  output logic        SYSCLKR_CE
);

  // state    | meaning
  // IDLE_CYC | internal operation, fast length, no strobes or selects
  // RD_CYC   | bus read, length from region decode, data sampled at last count
  // WR_CYC   | bus write, length from region decode, no response

  localparam logic [3:0] L_FAST  = 4'(FAST_LEN);
  localparam logic [3:0] L_SLOW  = 4'(SLOW_LEN);
  localparam logic [3:0] L_XSLOW = 4'(XSLOW_LEN);

  typedef enum logic [1:0] {IDLE_CYC, RD_CYC, WR_CYC} cyc_t;

  cyc_t        st, st_n;
  logic        run;
  logic [3:0]  cnt, cnt_n, len, len_n, rpos_n;
  logic        ready_q, ce_f_q, ce_r_q, rsp_valid_q;
  logic        boundary, accept, rd_done;
  logic [7:0]  bank;
  logic [15:0] off;
  logic        low_bank, wram_bank;
  logic [3:0]  dec_len;
  logic        dec_rom_n, dec_ram_n;

  assign bank      = REQ_ADDR[23:16];
  assign off       = REQ_ADDR[15:0];
  assign low_bank  = ~bank[6];
  assign wram_bank = (bank[7:1] == 7'h3F);

  always_comb begin
    dec_len = L_SLOW;
    if (low_bank) begin
      if (off < 16'h2000)                   dec_len = L_SLOW;
      else if (off < 16'h4000)              dec_len = L_FAST;
      else if (off < 16'h4200)              dec_len = L_XSLOW;
      else if (off < 16'h6000)              dec_len = L_FAST;
      else if (bank[7] && off[15] && MEMSEL) dec_len = L_FAST;
      else                                  dec_len = L_SLOW;
    end else if (bank[7] && MEMSEL) begin
      dec_len = L_FAST;
    end
    dec_rom_n = low_bank ? ~off[15] : wram_bank;
    dec_ram_n = low_bank ? ~(off < 16'h2000) : ~wram_bank;
  end

  assign boundary = run && (cnt == len - 4'd1);
  assign accept   = boundary && REQ_VALID;
  assign rd_done  = boundary && (st == RD_CYC);

  // The first enabled clock after reset only starts cycle 0 so its CE is visible.
  always_comb begin
    st_n  = st;
    cnt_n = cnt + 4'd1;
    len_n = len;
    if (!run) begin
      st_n  = IDLE_CYC;
      cnt_n = 4'd0;
      len_n = L_FAST;
    end else if (boundary) begin
      cnt_n = 4'd0;
      if (REQ_VALID) begin
        st_n  = REQ_WE ? WR_CYC : RD_CYC;
        len_n = dec_len;
      end else begin
        st_n  = IDLE_CYC;
        len_n = L_FAST;
      end
    end
    rpos_n = len_n - 4'd4;
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      run         <= 1'b0;
      st          <= IDLE_CYC;
      cnt         <= 4'd0;
      len         <= L_FAST;
      ready_q     <= 1'b0;
      ce_f_q      <= 1'b0;
      ce_r_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      RSP_DATA    <= 8'h00;
      CA          <= 24'h000000;
      BUS_DO      <= 8'h00;
      CPURD_N     <= 1'b1;
      CPUWR_N     <= 1'b1;
      ROMSEL_N    <= 1'b1;
      RAMSEL_N    <= 1'b1;
    end else if (ENABLE) begin
      run     <= 1'b1;
      st      <= st_n;
      cnt     <= cnt_n;
      len     <= len_n;
      ce_f_q  <= (cnt_n == 4'd0);
      ce_r_q  <= (cnt_n == rpos_n);
      ready_q <= (cnt_n == len_n - 4'd1);
      CPURD_N <= !((st_n == RD_CYC) && (cnt_n >= 4'd2));
      CPUWR_N <= !((st_n == WR_CYC) && (cnt_n >= rpos_n));
      rsp_valid_q <= rd_done;
      if (rd_done) RSP_DATA <= BUS_DI;
      if (accept) begin
        CA       <= REQ_ADDR;
        ROMSEL_N <= dec_rom_n;
        RAMSEL_N <= dec_ram_n;
        if (REQ_WE) BUS_DO <= REQ_WDATA;
      end else if (boundary) begin
        ROMSEL_N <= 1'b1;
        RAMSEL_N <= 1'b1;
      end
    end
  end

  assign REQ_READY  = ready_q & ENABLE;
  assign RSP_VALID  = rsp_valid_q & ENABLE;
  assign SYSCLKF_CE = ce_f_q & ENABLE;
  assign SYSCLKR_CE = ce_r_q & ENABLE;

endmodule

// File: tb/tb_snes_cpu_bus_master.sv
// Randomized and directed bench for snes_cpu_bus_master; expectations come from
// region/timing rules evaluated per transaction.
module tb_snes_cpu_bus_master;

  logic        MCLK, RST_N, ENABLE, MEMSEL;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [23:0] REQ_ADDR, CA;
  logic [7:0]  REQ_WDATA, RSP_DATA, BUS_DO, BUS_DI;
  logic        RSP_VALID, CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N, SYSCLKF_CE, SYSCLKR_CE;

  snes_cpu_bus_master dut (
    .MCLK(MCLK), .RST_N(RST_N), .ENABLE(ENABLE), .MEMSEL(MEMSEL),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_WE(REQ_WE), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .CA(CA), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI),
    .CPURD_N(CPURD_N), .CPUWR_N(CPUWR_N), .ROMSEL_N(ROMSEL_N),
    .RAMSEL_N(RAMSEL_N), .SYSCLKF_CE(SYSCLKF_CE), .SYSCLKR_CE(SYSCLKR_CE)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference timing rules
  function automatic int exp_len(input logic [23:0] ad, input logic ms);
    logic [7:0]  b;
    logic [15:0] a;
    b = ad[23:16];
    a = ad[15:0];
    if (b <= 8'h3F || (b >= 8'h80 && b <= 8'hBF)) begin
      if (a < 16'h2000) return 8;
      if (a < 16'h4000) return 6;
      if (a < 16'h4200) return 12;
      if (a < 16'h6000) return 6;
      if (b >= 8'h80 && a >= 16'h8000 && ms) return 6;
      return 8;
    end
    if (b <= 8'h7F) return 8;
    return ms ? 6 : 8;
  endfunction

  function automatic bit exp_rom(input logic [23:0] ad);
    logic [7:0] b;
    b = ad[23:16];
    if (b <= 8'h3F || (b >= 8'h80 && b <= 8'hBF)) return ad[15];
    return (b <= 8'h7D) || (b >= 8'hC0);
  endfunction

  function automatic bit exp_ram(input logic [23:0] ad);
    logic [7:0] b;
    b = ad[23:16];
    if (b <= 8'h3F || (b >= 8'h80 && b <= 8'hBF)) return ad[15:0] < 16'h2000;
    return (b == 8'h7E) || (b == 8'h7F);
  endfunction

  logic [23:0] s_addr[0:7];
  logic        s_we[0:7];
  logic [7:0]  s_wd[0:7];
  logic [7:0]  s_di[0:7];
  logic        s_ms[0:7];
  int          s_n;
  int          stall_idx = -1;
  logic [7:0]  last_wd;
  logic [23:0] cur_addr;
  int c_rom, c_ram, c_rd, c_rd_first, c_wr, c_wr_first, c_cer, c_ca_bad;
  int c_rsp_mid, c_cef_mid, c_gate_bad;

  task automatic set_entry(input int j, input logic [23:0] ad, input logic we,
                           input logic [7:0] wd, input logic [7:0] di, input logic ms);
    s_addr[j] = ad; s_we[j] = we; s_wd[j] = wd; s_di[j] = di; s_ms[j] = ms;
  endtask

  task automatic drive_entry(input int j);
    if (j < s_n) begin
      REQ_VALID = 1'b1; REQ_ADDR = s_addr[j]; REQ_WE = s_we[j];
      REQ_WDATA = s_wd[j]; MEMSEL = s_ms[j];
    end else begin
      REQ_VALID = 1'b0; REQ_ADDR = 24'($urandom); REQ_WE = 1'($urandom);
      REQ_WDATA = 8'($urandom);
    end
  endtask

  task automatic sample(input int k);
    if (!ROMSEL_N) c_rom++;
    if (!RAMSEL_N) c_ram++;
    if (!CPURD_N) begin c_rd++; if (c_rd_first < 0) c_rd_first = k; end
    if (!CPUWR_N) begin c_wr++; if (c_wr_first < 0) c_wr_first = k; end
    if (SYSCLKR_CE && c_cer < 0) c_cer = k;
    if (CA != cur_addr) c_ca_bad++;
    if (k > 0 && RSP_VALID) c_rsp_mid++;
    if (k > 0 && SYSCLKF_CE) c_cef_mid++;
  endtask

  // Issues s_n requests; each is accepted at the first boundary it sees.
  task automatic run_seq();
    int guard, k, span, len, el, ex;
    drive_entry(0);
    guard = 0;
    while (!REQ_READY && guard < 40) begin @(negedge MCLK); guard++; end
    if (!REQ_READY) begin
      chk("accept_timeout", 0, 1);
      REQ_VALID = 1'b0;
      return;
    end
    @(negedge MCLK);
    for (int j = 0; j <= s_n; j++) begin
      chk("sysclkf_start", SYSCLKF_CE, 1);
      if (j > 0) begin
        chk("rsp_valid", RSP_VALID, s_we[j-1] ? 0 : 1);
        if (!s_we[j-1]) chk("rsp_data", RSP_DATA, s_di[j-1]);
      end
      if (j == s_n) break;
      BUS_DI   = s_di[j];
      cur_addr = s_addr[j];
      chk("bus_do", BUS_DO, s_we[j] ? s_wd[j] : last_wd);
      if (s_we[j]) last_wd = s_wd[j];
      drive_entry(j + 1);
      c_rom = 0; c_ram = 0; c_rd = 0; c_rd_first = -1; c_wr = 0; c_wr_first = -1;
      c_cer = -1; c_ca_bad = 0; c_rsp_mid = 0; c_cef_mid = 0; c_gate_bad = 0;
      k = 0; span = 0; len = 0;
      while (len == 0 && k < 20) begin
        sample(k);
        if (j == stall_idx && k == 3) begin
          ENABLE = 1'b0;
          repeat (5) begin
            @(negedge MCLK);
            span++;
            sample(3);
            if (SYSCLKF_CE || SYSCLKR_CE || REQ_READY || RSP_VALID) c_gate_bad++;
          end
          ENABLE = 1'b1;
        end
        if (REQ_READY) len = k + 1;
        else begin @(negedge MCLK); k++; span++; end
      end
      if (len == 0) begin
        chk("ready_timeout", 0, 1);
        REQ_VALID = 1'b0;
        return;
      end
      el = exp_len(s_addr[j], s_ms[j]);
      ex = (j == stall_idx) ? 5 : 0;
      chk("cycle_len", len, el);
      chk("cycle_span", span, el - 1 + ex);
      chk("romsel_low", c_rom, exp_rom(s_addr[j]) ? el + ex : 0);
      chk("ramsel_low", c_ram, exp_ram(s_addr[j]) ? el + ex : 0);
      chk("cpurd_low", c_rd, s_we[j] ? 0 : el - 2 + ex);
      chk("cpurd_first", c_rd_first, s_we[j] ? -1 : 2);
      chk("cpuwr_low", c_wr, s_we[j] ? 4 : 0);
      chk("cpuwr_first", c_wr_first, s_we[j] ? el - 4 : -1);
      chk("sysclkr_pos", c_cer, el - 4);
      chk("ca_unstable", c_ca_bad, 0);
      chk("rsp_mid", c_rsp_mid, 0);
      chk("sysclkf_mid", c_cef_mid, 0);
      if (ex != 0) chk("gated_outputs", c_gate_bad, 0);
      @(negedge MCLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [15:0] bases[0:7] = '{16'h0000, 16'h2000, 16'h4000, 16'h4100,
                               16'h4200, 16'h6000, 16'h8000, 16'hFF00};

  initial begin
    int bad_f, bad_r, bad_s, bad_ca, rsp_seen;
    RST_N = 1'b0; ENABLE = 1'b1; MEMSEL = 1'b0; REQ_VALID = 1'b0;
    REQ_ADDR = 24'h0; REQ_WE = 1'b0; REQ_WDATA = 8'h0; BUS_DI = 8'h0;
    last_wd = 8'h00; cur_addr = 24'h0;
    repeat (3) @(negedge MCLK);
    chk("rst_ca", CA, 0);
    chk("rst_bus_do", BUS_DO, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_strobes", {CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N}, 15);
    chk("rst_ces", {SYSCLKF_CE, SYSCLKR_CE}, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);

    // Idle cadence after reset release
    RST_N = 1'b1;
    bad_f = 0; bad_r = 0; bad_s = 0; bad_ca = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge MCLK);
      if (SYSCLKF_CE != ((k % 6) == 0)) bad_f++;
      if (SYSCLKR_CE != ((k % 6) == 2)) bad_r++;
      if (!(CPURD_N && CPUWR_N && ROMSEL_N && RAMSEL_N)) bad_s++;
      if (CA != 24'h0) bad_ca++;
    end
    chk("idle_sysclkf", bad_f, 0);
    chk("idle_sysclkr", bad_r, 0);
    chk("idle_strobes", bad_s, 0);
    chk("idle_ca", bad_ca, 0);

    s_n = 1; set_entry(0, 24'h008000, 1'b0, 8'h00, 8'hA5, 1'b0); run_seq();

    s_n = 4;
    set_entry(0, 24'h808000, 1'b0, 8'h00, 8'h11, 1'b1);
    set_entry(1, 24'hC00000, 1'b0, 8'h00, 8'h22, 1'b1);
    set_entry(2, 24'h808000, 1'b0, 8'h00, 8'h33, 1'b0);
    set_entry(3, 24'hC00000, 1'b0, 8'h00, 8'h44, 1'b0);
    run_seq();

    s_n = 2;
    set_entry(0, 24'h306000, 1'b1, 8'h5A, 8'h99, 1'b0);
    set_entry(1, 24'h700000, 1'b1, 8'h3C, 8'h98, 1'b0);
    run_seq();

    s_n = 2;
    set_entry(0, 24'h004016, 1'b0, 8'h00, 8'h6B, 1'b0);
    set_entry(1, 24'h7E1234, 1'b0, 8'h00, 8'hC7, 1'b0);
    run_seq();

    s_n = 3;
    set_entry(0, 24'h008000, 1'b0, 8'h00, 8'h01, 1'b0);
    set_entry(1, 24'h008001, 1'b0, 8'h00, 8'h02, 1'b0);
    set_entry(2, 24'h008002, 1'b0, 8'h00, 8'h03, 1'b0);
    run_seq();

    s_n = 1; stall_idx = 0;
    set_entry(0, 24'h008000, 1'b0, 8'h00, 8'hE1, 1'b0);
    run_seq();
    stall_idx = -1;

    for (int r = 0; r < 8; r++) begin
      s_n = $urandom_range(1, 4);
      for (int j = 0; j < s_n; j++)
        set_entry(j, {8'($urandom), bases[$urandom_range(0, 7)] + 16'($urandom_range(0, 255))},
                  1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      run_seq();
    end

    // Reset in the middle of a read
    s_n = 1; set_entry(0, 24'h008000, 1'b0, 8'h00, 8'h77, 1'b0);
    drive_entry(0);
    bad_f = 0;
    while (!REQ_READY && bad_f < 40) begin @(negedge MCLK); bad_f++; end
    @(negedge MCLK);
    BUS_DI = 8'h77;
    REQ_VALID = 1'b0;
    repeat (3) @(negedge MCLK);
    chk("pre_reset_rd", CPURD_N, 0);
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_strobes", {CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N}, 15);
    chk("midrst_ca", CA, 0);
    chk("midrst_ces_ready", {SYSCLKF_CE, SYSCLKR_CE, REQ_READY, RSP_VALID}, 0);
    last_wd = 8'h00;
    @(negedge MCLK);
    RST_N = 1'b1;
    @(negedge MCLK);
    chk("post_rst_sysclkf", SYSCLKF_CE, 1);
    rsp_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (RSP_VALID) rsp_seen++;
      @(negedge MCLK);
    end
    chk("post_rst_no_rsp", rsp_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
